// File: rtl/kuznechik_arbiter.sv
// kuznechik_arbiter: round-robin share of one kuznechik_cipher core among N_REQ requesters.
// Latency: req_i sampled -> grant_o/core_request_o 1 cycle; core_valid_i sampled -> resp_valid_o 1 cycle.
// Backpressure: a winner is picked only while core_busy_i is low; result is held until resp_ack_i[idx].
//
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   req_i, req_data_i      per-requester level request and 128-bit plaintext (slot k at [128k+127:128k])
//   grant_o                one-cycle one-hot pulse: winner's plaintext latched
//   resp_valid_o/_data_o   one-hot result valid and shared ciphertext, held until resp_ack_i[idx]
//   resp_ack_i             per-requester result consumed
//   busy_o                 high outside IDLE
//   core_*                 handshake towards the cipher core
module kuznechik_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [128*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic [N_REQ-1:0]     resp_valid_o,
  input  logic [N_REQ-1:0]     resp_ack_i,
  output logic [127:0]         resp_data_o,
  output logic                 busy_o,
  output logic                 core_request_o,
  output logic [127:0]         core_data_o,
  output logic                 core_ack_o,
  input  logic [127:0]         core_data_i,
  input  logic                 core_valid_i,
  input  logic                 core_busy_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_CORE, DELIVER} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      last_idx_q, last_idx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [127:0]       resp_data_q, resp_data_d;
  logic               core_request_q, core_request_d;
  logic [127:0]       core_data_q, core_data_d;
  logic               core_ack_q, core_ack_d;
  logic               busy_q, busy_d;

  // Round-robin search: rotate a doubled request vector so bit 0 is the
  // slot after last_idx, take the lowest set bit, then map back modulo N_REQ.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IW-1:0]      rot_pos;
  logic [IW:0]        win_sum;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic [127:0]       win_data;
  logic               start;
  logic               ack_hit;

  always_comb begin
    req_dbl  = {req_i, req_i};
    req_rot  = req_dbl[N_REQ-1:0];
    req_rot  = N_REQ'(req_dbl >> ({1'b0, last_idx_q} + 1'b1));
    rot_pos  = '0;
    win_vld  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rot_pos = IW'(i);
        win_vld = 1'b1;
      end
    end
    win_sum = {1'b0, last_idx_q} + {1'b0, rot_pos} + 1'b1;
    if (win_sum >= (IW+1)'(N_REQ)) begin
      win_sum = win_sum - (IW+1)'(N_REQ);
    end
    win_idx  = win_sum[IW-1:0];
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_data = req_data_i[128*i +: 128];
      end
    end
  end

  assign start   = (state_q == IDLE) && win_vld && !core_busy_i;
  // resp_valid_q is one-hot at idx in DELIVER, so acks from other slots drop out.
  assign ack_hit = |(resp_ack_i & resp_valid_q);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)        state_d = WAIT_CORE;
      WAIT_CORE: if (core_valid_i) state_d = DELIVER;
      DELIVER:   if (ack_hit)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    idx_d          = idx_q;
    last_idx_d     = last_idx_q;
    grant_d        = '0;
    resp_valid_d   = resp_valid_q;
    resp_data_d    = resp_data_q;
    core_request_d = 1'b0;
    core_data_d    = core_data_q;
    core_ack_d     = 1'b0;
    busy_d         = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d          = win_idx;
          core_data_d    = win_data;
          grant_d        = N_REQ'(1) << win_idx;
          core_request_d = 1'b1;
        end
      end
      WAIT_CORE: begin
        if (core_valid_i) begin
          resp_data_d  = core_data_i;
          resp_valid_d = N_REQ'(1) << idx_q;
          core_ack_d   = 1'b1;
        end
      end
      DELIVER: begin
        if (ack_hit) begin
          resp_valid_d = '0;
          last_idx_d   = idx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q          <= '0;
      last_idx_q     <= IW'(N_REQ - 1);
      grant_q        <= '0;
      resp_valid_q   <= '0;
      resp_data_q    <= '0;
      core_request_q <= 1'b0;
      core_data_q    <= '0;
      core_ack_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      last_idx_q     <= last_idx_d;
      grant_q        <= grant_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      core_request_q <= core_request_d;
      core_data_q    <= core_data_d;
      core_ack_q     <= core_ack_d;
      busy_q         <= busy_d;
    end
  end

  assign grant_o        = grant_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_data_o    = resp_data_q;
  assign core_request_o = core_request_q;
  assign core_data_o    = core_data_q;
  assign core_ack_o     = core_ack_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_kuznechik_arbiter.sv
module tb_kuznechik_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i;
  logic [511:0] req_data_i;
  logic [3:0]   grant_o;
  logic [3:0]   resp_valid_o;
  logic [3:0]   resp_ack_i;
  logic [127:0] resp_data_o;
  logic         busy_o;
  logic         core_request_o;
  logic [127:0] core_data_o;
  logic         core_ack_o;
  logic [127:0] core_data_i;
  logic         core_valid_i;
  logic         core_busy_i;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] P0 = 128'ha5ff3b17aa3368ffeda5d628bc671622;
  localparam logic [127:0] P1 = 128'h11111111111111112222222222222222;
  localparam logic [127:0] P2 = 128'h33333333333333334444444444444444;
  localparam logic [127:0] P3 = 128'h55555555555555556666666666666666;
  localparam logic [127:0] C0 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] CX = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  kuznechik_arbiter #(.N_REQ(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .req_data_i     (req_data_i),
    .grant_o        (grant_o),
    .resp_valid_o   (resp_valid_o),
    .resp_ack_i     (resp_ack_i),
    .resp_data_o    (resp_data_o),
    .busy_o         (busy_o),
    .core_request_o (core_request_o),
    .core_data_o    (core_data_o),
    .core_ack_o     (core_ack_o),
    .core_data_i    (core_data_i),
    .core_valid_i   (core_valid_i),
    .core_busy_i    (core_busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change right after a falling edge; outputs are read at the next
  // falling edge, i.e. half a cycle after the rising edge that produced them.
  task automatic step();
    @(negedge clk_i);
  endtask

  logic [127:0] exp_plain [4];
  int           exp_k;
  logic [3:0]   oh;

  initial begin
    exp_plain[0] = P0; exp_plain[1] = P1; exp_plain[2] = P2; exp_plain[3] = P3;
    rst_i        = 1'b1;
    req_i        = '0;
    resp_ack_i   = '0;
    core_valid_i = 1'b0;
    core_busy_i  = 1'b0;
    core_data_i  = '0;
    req_data_i   = {P3, P2, P1, P0};

    // Reset state
    step();
    chk("rst_grant",  128'(grant_o), 128'(0));
    chk("rst_rvalid", 128'(resp_valid_o), 128'(0));
    chk("rst_rdata",  resp_data_o, 128'(0));
    chk("rst_ctrl",   128'({busy_o, core_request_o, core_ack_o}), 128'(0));
    chk("rst_cdata",  core_data_o, 128'(0));
    rst_i = 1'b0;

    // Single request to requester 0
    req_i = 4'b0001;
    step();
    chk("t1_grant",  128'(grant_o), 128'(4'b0001));
    chk("t1_creq",   128'({core_request_o, core_ack_o, busy_o}), 128'(3'b101));
    chk("t1_cdata",  core_data_o, P0);
    req_i = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_quiet", 128'({grant_o, core_request_o, busy_o}), 128'(6'b0000_0_1));
    end
    core_valid_i = 1'b1;
    core_data_i  = C0;
    step();
    chk("t1_rvalid", 128'(resp_valid_o), 128'(4'b0001));
    chk("t1_rdata",  resp_data_o, C0);
    chk("t1_cack",   128'({core_ack_o, core_request_o}), 128'(2'b10));
    // A stray core_valid_i in DELIVER must not disturb the held result
    core_data_i = CX;
    step();
    chk("t1_hold_rd", resp_data_o, C0);
    chk("t1_hold_ct", 128'({resp_valid_o, core_ack_o, busy_o}), 128'(6'b0001_0_1));
    core_valid_i = 1'b0;
    resp_ack_i   = 4'b0001;
    step();
    chk("t1_done", 128'({resp_valid_o, busy_o}), 128'(5'b0000_0));
    resp_ack_i = '0;

    // Round robin from a fresh reset: expected order 0,1,2,3,0
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_k = n % 4;
      oh    = 4'b0001 << exp_k;
      step();
      chk("rr_grant", 128'(grant_o), 128'(oh));
      chk("rr_cdata", core_data_o, exp_plain[exp_k]);
      core_valid_i = 1'b1;
      core_data_i  = C0 ^ 128'(n);
      step();
      chk("rr_rvalid", 128'(resp_valid_o), 128'(oh));
      chk("rr_rdata",  resp_data_o, C0 ^ 128'(n));
      core_valid_i = 1'b0;
      resp_ack_i   = oh;
      step();
      // ack edge with requests pending: back to IDLE, no grant on this edge
      chk("rr_gap", 128'({grant_o, resp_valid_o, busy_o}), 128'(0));
      resp_ack_i = '0;
    end
    req_i = '0;

    // Core busy holds off the grant
    core_busy_i = 1'b1;
    req_i       = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("cb_none", 128'({grant_o, core_request_o, busy_o}), 128'(0));
    end
    core_busy_i = 1'b0;
    step();
    chk("cb_grant", 128'({grant_o, core_request_o}), 128'(5'b0100_1));
    req_i = 4'b0000;

    // Delayed ack on requester 2, stray ack on requester 1, new request pending
    core_valid_i = 1'b1;
    core_data_i  = C0;
    step();
    core_valid_i = 1'b0;
    core_data_i  = CX;
    req_i        = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      resp_ack_i = (i == 5) ? 4'b0010 : 4'b0000;
      step();
      chk("da_ctl",  128'({resp_valid_o, busy_o, grant_o}), 128'(9'b0100_1_0000));
      chk("da_data", resp_data_o, C0);
    end
    resp_ack_i = 4'b0100;
    step();
    chk("da_release", 128'({resp_valid_o, busy_o, grant_o}), 128'(0));
    resp_ack_i = '0;
    step();
    chk("da_next", 128'(grant_o), 128'(4'b0001));
    req_i = '0;
    step();
    chk("wc_busy", 128'({busy_o, grant_o}), 128'(5'b1_0000));

    // Asynchronous reset while waiting for the core
    #2 rst_i = 1'b1;
    #1;
    chk("ar_ctl",  128'({grant_o, resp_valid_o, busy_o, core_request_o, core_ack_o}), 128'(0));
    chk("ar_cd",   core_data_o, 128'(0));
    chk("ar_rd",   resp_data_o, 128'(0));
    core_valid_i = 1'b1;
    core_data_i  = C0;
    core_busy_i  = 1'b1;
    req_i        = 4'b0001;
    step();
    rst_i = 1'b0;
    step();
    chk("ar_ign", 128'({resp_valid_o, core_ack_o, grant_o, core_request_o, busy_o}), 128'(0));
    core_valid_i = 1'b0;
    core_busy_i  = 1'b0;
    step();
    chk("ar_grant", 128'({grant_o, core_request_o}), 128'(5'b0001_1));
    chk("ar_cdata", core_data_o, P0);
    req_i = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kuznechik_arbiter.md
KUZNECHIK_ARBITER -- requirements
Module: kuznechik_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one kuznechik_cipher core (2..8).
REQ-002 SHALL have ports as listed below; clock and reset first.
- clk_i  in  1  single clock, all logic rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  N_REQ  per-requester cipher request, level.
- req_data_i  in  128*N_REQ  plaintext; requester k at bits [128k+127:128k].
- grant_o  out  N_REQ  one-hot, one-cycle pulse: requester's data latched.
- resp_valid_o  out  N_REQ  one-hot, result for requester k available.
- resp_ack_i  in  N_REQ  requester k consumed result.
- resp_data_o  out  128  ciphertext, shared, valid while any resp_valid_o bit is high.
- busy_o  out  1  arbiter not in IDLE.
- core_request_o  out  1  to core request_i, one-cycle pulse.
- core_data_o  out  128  to core data_i.
- core_ack_o  out  1  to core ack_i, one-cycle pulse.
- core_data_i  in  128  from core data_o.
- core_valid_i  in  1  from core valid_o.
- core_busy_i  in  1  from core busy_o.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_CORE, DELIVER; all outputs registered.
REQ-004 IDLE: at an edge where any req_i bit is high and core_busy_i is low, SHALL select winner idx, latch req_data_i[idx] into core_data_o, pulse grant_o[idx] and core_request_o high for exactly the following cycle, go to WAIT_CORE.
REQ-005 IDLE with core_busy_i high SHALL issue nothing and SHALL NOT pulse grant_o.
REQ-006 Winner selection SHALL be round-robin: search starts at (last_idx+1) mod N_REQ, first set req_i bit wins.
REQ-007 last_idx SHALL update to idx on completion of DELIVER only.
REQ-008 WAIT_CORE: at the edge where core_valid_i is high, SHALL capture core_data_i into resp_data_o, set resp_valid_o[idx], pulse core_ack_o for one cycle, go to DELIVER.
REQ-009 core_valid_i SHALL be ignored in IDLE and DELIVER.
REQ-010 DELIVER: SHALL hold resp_valid_o[idx] and resp_data_o stable until resp_ack_i[idx] is sampled high, then clear resp_valid_o and return to IDLE.
REQ-011 resp_ack_i bits other than idx, and resp_ack_i in IDLE/WAIT_CORE, SHALL be ignored.
REQ-012 Earliest next grant SHALL be the edge after the ack edge (one IDLE cycle minimum between transactions).
REQ-013 Requester SHALL drop req_i the cycle after its grant_o; req_i still high in IDLE is a new request.
REQ-014 busy_o SHALL be high in WAIT_CORE and DELIVER, low in IDLE.
REQ-015 At most one bit of grant_o and of resp_valid_o SHALL be high at any time; core_request_o and core_ack_o SHALL never be high together.
REQ-016 Latency req_i sampled -> core_request_o: 1 cycle; core_valid_i sampled -> resp_valid_o: 1 cycle.

Reset
REQ-017 rst_i high SHALL immediately force state IDLE, last_idx = N_REQ-1, and all outputs (grant_o, resp_valid_o, resp_data_o, core_request_o, core_data_o, core_ack_o, busy_o) to 0.
REQ-018 After reset mid-operation the arbiter SHALL issue no request until core_busy_i is sampled low; a core_valid_i left pending from before reset SHALL be ignored (IDLE).

Verification
REQ-019 Single request: req_i=4'b0001, req_data_i[0]=128'ha5ff3b17aa3368ffeda5d628bc671622, stub core valid 5 cycles after request with 128'h0123..ef -> grant_o=0001 one cycle, core_data_o = plaintext, core_ack_o one pulse, resp_valid_o=0001, resp_data_o=128'h0123..ef until resp_ack_i[0].
REQ-020 Round robin: req_i=4'b1111 held (re-raised after each grant) -> grant order 0,1,2,3,0; no requester granted twice before all others.
REQ-021 Core busy: core_busy_i=1 with req_i=4'b0100 for 10 cycles -> no grant_o, no core_request_o; first grant one cycle after core_busy_i drops.
REQ-022 Delayed ack: resp_ack_i[2] withheld 20 cycles, resp_ack_i[1] pulsed meanwhile -> resp_valid_o=0100 and resp_data_o stable throughout, busy_o=1, no new grant.
REQ-023 Reset mid-operation: rst_i asserted in WAIT_CORE -> all outputs 0 asynchronously; subsequent core_valid_i=1 ignored; after release req_i=4'b0001 granted to requester 0.
REQ-024 Simultaneous events: resp_ack_i[idx] and new req_i on same edge -> return to IDLE, grant on the next edge, not the same one.
